// File: rtl/cla_pkg.sv
// Shared types and generate/propagate helpers for the pipelined carry-lookahead adder.
// Stage payload fields are sized to CLA_MAX_WIDTH; narrower instances leave the upper bits at zero.
package cla_pkg;

   localparam int CLA_WIDTH     = 16;
   localparam int CLA_GROUP     = 4;
   localparam int CLA_MAX_WIDTH = 64;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   // One pipeline stage: resolved sum bits, pending operands, carry out of the last slice,
   // and the carry into the MSB of the last slice resolved so far.
   typedef struct packed {
      logic [CLA_MAX_WIDTH-1:0] s;
      logic [CLA_MAX_WIDTH-1:0] a;
      logic [CLA_MAX_WIDTH-1:0] b;
      logic                     c;
      logic                     c_msb;
   } stage_t;

   function automatic gp_t bit_gp(input logic a, input logic b);
      gp_t r;
      r.g = a & b;
      r.p = a ^ b;
      return r;
   endfunction

   // Group generate/propagate for a higher span sitting on top of a lower span.
   function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit combinational carry-lookahead slice; also exposes the carry into its MSB
// so the top level can form signed overflow.
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = CLA_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             ci,
   output logic [GROUP-1:0] s,
   output logic             co,
   output logic             c_msb
);

   gp_t            bgp [GROUP];
   gp_t            pre [GROUP];
   logic [GROUP:0] c;

   always_comb begin
      // NOTE: combinational blocks use blocking assignments so each prefix term sees the one just computed.
      for (int i = 0; i < GROUP; i++) bgp[i] = bit_gp(a[i], b[i]);
      pre[0] = bgp[0];
      for (int i = 1; i < GROUP; i++) pre[i] = gp_combine(bgp[i], pre[i-1]);
      c[0] = ci;
      for (int i = 0; i < GROUP; i++) c[i+1] = pre[i].g | (pre[i].p & ci);
      for (int i = 0; i < GROUP; i++) s[i] = bgp[i].p ^ c[i];
   end

   assign co    = c[GROUP];
   assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit slice resolved per stage,
// carry registered between stages, valid/ready handshake with full backpressure.
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int GROUP = CLA_GROUP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / GROUP;

   if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0 || WIDTH > CLA_MAX_WIDTH) begin : g_bad_params
      $error("cla_pipe_adder: WIDTH must be a multiple of GROUP, at least GROUP, at most CLA_MAX_WIDTH");
   end

   stage_t              in_stage;
   stage_t              pipe [STAGES];
   stage_t              nxt  [STAGES];
   logic [STAGES-1:0]   vld;
   logic [STAGES-1:0]   vin;
   logic [STAGES-1:0]   rdy;

   always_comb begin
      // NOTE: every field gets a default first so no bit is left holding state (no latch).
      in_stage              = '0;
      in_stage.a[WIDTH-1:0] = a;
      in_stage.b[WIDTH-1:0] = sub ? ~b : b;
      in_stage.c            = sub | cin;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t           src;
      stage_t           n;
      logic [GROUP-1:0] slice_s;
      logic             slice_co;
      logic             slice_c_msb;

      if (k == 0) begin : g_first
         assign src    = in_stage;
         assign vin[k] = in_valid;
      end else begin : g_rest
         assign src    = pipe[k-1];
         assign vin[k] = vld[k-1];
      end

      cla_group #(.GROUP(GROUP)) u_cla (
         .a     (src.a[k*GROUP +: GROUP]),
         .b     (src.b[k*GROUP +: GROUP]),
         .ci    (src.c),
         .s     (slice_s),
         .co    (slice_co),
         .c_msb (slice_c_msb)
      );

      always_comb begin
         n                        = src;
         n.s[k*GROUP +: GROUP]    = slice_s;
         n.c                      = slice_co;
         n.c_msb                  = slice_c_msb;
      end

      assign nxt[k] = n;

      // A stage can take a beat unless it and every stage ahead of it are full and stalled.
      assign rdy[k] = out_ready | ~(&vld[STAGES-1:k]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
         // NOTE: payload registers are reset too, so flags and sum read as zero, never X, after reset.
         for (int k = 0; k < STAGES; k++) pipe[k] <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (rdy[k]) begin
               vld[k] <= vin[k];
               if (vin[k]) pipe[k] <= nxt[k];
            end
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = vld[STAGES-1];
   assign sum       = pipe[STAGES-1].s[WIDTH-1:0];
   assign cout      = pipe[STAGES-1].c;
   assign ovf       = pipe[STAGES-1].c ^ pipe[STAGES-1].c_msb;

endmodule
